// File: rtl/draw_cmd_exec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : draw_cmd_exec
// Brief    : Draw-command consumer. Buffers commands in a show-ahead FIFO and
//            expands point and rectangle-fill opcodes into logic-grid pixel writes.
// Revision : 1.0 - initial release
// ============================================================================
module draw_cmd_exec #(
   parameter int                       H_LOGIC_WIDTH  = 5,
   parameter int                       V_LOGIC_WIDTH  = 5,
   parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX    = 5'd31,
   parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX    = 5'd23,
   parameter int                       COLOR_ID_WIDTH = 8,
   parameter int                       FIFO_AW        = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [31:0]                            cmd,
   input  logic                                   cmd_vld,
   output logic                                   fb_we,
   output logic [V_LOGIC_WIDTH+H_LOGIC_WIDTH-1:0] fb_addr,
   output logic [COLOR_ID_WIDTH-1:0]              fb_wdata,
   output logic                                   busy,
   output logic [FIFO_AW:0]                       fifo_level,
   output logic                                   cmd_ovf
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int HW    = H_LOGIC_WIDTH;
   localparam int VW    = V_LOGIC_WIDTH;
   localparam int CW    = COLOR_ID_WIDTH;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------------
   logic [31:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   level_q, level_d;
   logic               ovf_q, ovf_d;
   logic               fifo_empty;
   logic               fifo_full;
   logic               push;
   logic               pop;

   assign fifo_empty = (level_q == '0);
   // Occupancy never exceeds DEPTH, so the top bit alone means full.
   assign fifo_full  = level_q[FIFO_AW];
   assign push       = cmd_vld & ~fifo_full;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q | (cmd_vld & fifo_full);
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd;
   end

   // ------------------------------------------------------------------------
   // Head-word decode
   // ------------------------------------------------------------------------
   logic [31:0]   head;
   logic [3:0]    op;
   logic [HW-1:0] f_x0, f_x1, x1_clip;
   logic [VW-1:0] f_y0, f_y1, y1_clip;
   logic [CW-1:0] pt_color, rect_color;
   logic          pt_oob;
   logic          rect_ok;

   assign head       = mem_q[rd_ptr_q];
   assign op         = head[31:28];
   assign f_x0       = head[27 -: HW];
   assign f_y0       = head[22 -: VW];
   assign pt_color   = head[17 -: CW];
   assign f_x1       = head[17 -: HW];
   assign f_y1       = head[12 -: VW];
   assign rect_color = head[CW-1:0];

   // Zero-extended compares keep the check meaningful when MAX is all-ones.
   assign pt_oob  = ({1'b0, f_x0} > {1'b0, H_LOGIC_MAX}) |
                    ({1'b0, f_y0} > {1'b0, V_LOGIC_MAX});
   assign x1_clip = ({1'b0, f_x1} > {1'b0, H_LOGIC_MAX}) ? H_LOGIC_MAX : f_x1;
   assign y1_clip = ({1'b0, f_y1} > {1'b0, V_LOGIC_MAX}) ? V_LOGIC_MAX : f_y1;
   assign rect_ok = (f_x0 <= x1_clip) && (f_y0 <= y1_clip);

   // ------------------------------------------------------------------------
   // Execution FSM
   // ------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [HW-1:0]    cx_q, cx_d, x0_q, x0_d, x1_q, x1_d;
   logic [VW-1:0]    cy_q, cy_d, y1_q, y1_d;
   logic [CW-1:0]    color_q, color_d;
   logic             fb_we_q, fb_we_d;
   logic [VW+HW-1:0] fb_addr_q, fb_addr_d;
   logic [CW-1:0]    fb_wdata_q, fb_wdata_d;

   always_comb begin
      state_d    = state_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      x0_d       = x0_q;
      x1_d       = x1_q;
      y1_d       = y1_q;
      color_d    = color_q;
      fb_we_d    = 1'b0;
      fb_addr_d  = fb_addr_q;
      fb_wdata_d = fb_wdata_q;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (op == 4'd0 && !pt_oob) begin
                  fb_we_d    = 1'b1;
                  fb_addr_d  = {f_y0, f_x0};
                  fb_wdata_d = pt_color;
               end else if (op == 4'd1 && rect_ok) begin
                  cx_d    = f_x0;
                  cy_d    = f_y0;
                  x0_d    = f_x0;
                  x1_d    = x1_clip;
                  y1_d    = y1_clip;
                  color_d = rect_color;
                  state_d = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            fb_we_d    = 1'b1;
            fb_addr_d  = {cy_q, cx_q};
            fb_wdata_d = color_q;
            if (cx_q == x1_q) begin
               cx_d = x0_q;
               cy_d = cy_q + 1'b1;
               if (cy_q == y1_q) state_d = ST_IDLE;
            end else begin
               cx_d = cx_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         state_q    <= ST_IDLE;
         cx_q       <= '0;
         cy_q       <= '0;
         x0_q       <= '0;
         x1_q       <= '0;
         y1_q       <= '0;
         color_q    <= '0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         x0_q       <= x0_d;
         x1_q       <= x1_d;
         y1_q       <= y1_d;
         color_q    <= color_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_wdata_q <= fb_wdata_d;
      end
   end

   assign fb_we      = fb_we_q;
   assign fb_addr    = fb_addr_q;
   assign fb_wdata   = fb_wdata_q;
   assign fifo_level = level_q;
   assign cmd_ovf    = ovf_q;
   assign busy       = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_draw_cmd_exec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_draw_cmd_exec
// Brief    : Directed self-checking bench for draw_cmd_exec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_cmd_exec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cmd = '0;
   logic        cmd_vld = 1'b0;
   logic        fb_we;
   logic [9:0]  fb_addr;
   logic [7:0]  fb_wdata;
   logic        busy;
   logic [4:0]  fifo_level;
   logic        cmd_ovf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int         wr_cyc  [$];
   logic [9:0] wr_addr [$];
   logic [7:0] wr_data [$];

   localparam logic [31:0] CLEAR    = 32'h1003F7FF;
   localparam logic [31:0] CLEAR_Y31 = 32'h1003FFFF;
   localparam logic [31:0] PT35     = 32'h01943C00;

   draw_cmd_exec dut (
      .clk        (clk),
      .rst        (rst),
      .cmd        (cmd),
      .cmd_vld    (cmd_vld),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_wdata   (fb_wdata),
      .busy       (busy),
      .fifo_level (fifo_level),
      .cmd_ovf    (cmd_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write log sampled on the falling edge, cycle-stamped.
   always @(negedge clk) begin
      if (fb_we) begin
         wr_cyc.push_back(cyc);
         wr_addr.push_back(fb_addr);
         wr_data.push_back(fb_wdata);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   function automatic logic [31:0] pt(input logic [4:0] x, input logic [4:0] y, input logic [7:0] c);
      return {4'h0, x, y, c, 10'd0};
   endfunction

   function automatic logic [31:0] rect(input logic [4:0] x0, input logic [4:0] y0,
                                        input logic [4:0] x1, input logic [4:0] y1,
                                        input logic [7:0] c);
      return {4'h1, x0, y0, x1, y1, c};
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] w);
      cmd     = w;
      cmd_vld = 1'b1;
      step();
      cmd_vld = 1'b0;
   endtask

   task automatic log_clear();
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic wait_idle(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         step();
         if (!busy) ok = 1'b1;
      end
      step();
      step();
   endtask

   task automatic test_reset();
      #12;
      total++; if (fb_we !== 1'b0)      begin bad++; $display("FAIL rst_we: got %0d want 0", fb_we); end
      total++; if (fb_addr !== 10'd0)   begin bad++; $display("FAIL rst_addr: got %0d want 0", fb_addr); end
      total++; if (fb_wdata !== 8'd0)   begin bad++; $display("FAIL rst_wdata: got %0h want 0", fb_wdata); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %0d want 0", busy); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
      total++; if (cmd_ovf !== 1'b0)    begin bad++; $display("FAIL rst_ovf: got %0d want 0", cmd_ovf); end
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_point();
      int t;
      log_clear();
      send(PT35);
      t = cyc - 1;
      total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL pt_level1: got %0d want 1", fifo_level); end
      total++; if (fb_we !== 1'b0)      begin bad++; $display("FAIL pt_we_early: got %0d want 0", fb_we); end
      total++; if (busy !== 1'b1)       begin bad++; $display("FAIL pt_busy: got %0d want 1", busy); end
      step();
      total++; if (fb_we !== 1'b1)      begin bad++; $display("FAIL pt_we: got %0d want 1", fb_we); end
      total++; if (fb_addr !== 10'd163) begin bad++; $display("FAIL pt_addr: got %0d want 163", fb_addr); end
      total++; if (fb_wdata !== 8'h0F)  begin bad++; $display("FAIL pt_data: got %0h want 0f", fb_wdata); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL pt_level0: got %0d want 0", fifo_level); end
      step();
      total++; if (fb_we !== 1'b0)      begin bad++; $display("FAIL pt_we_strobe: got %0d want 0", fb_we); end
      total++; if (fb_addr !== 10'd163) begin bad++; $display("FAIL pt_addr_hold: got %0d want 163", fb_addr); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL pt_busy_drop: got %0d want 0", busy); end
      step();
      total++; if (wr_cyc.size() != 1 || wr_cyc[0] != t + 2)
         begin bad++; $display("FAIL pt_timing: got n=%0d c=%0d want n=1 c=%0d", wr_cyc.size(), (wr_cyc.size() > 0) ? wr_cyc[0] - t : -1, 2); end
   endtask

   task automatic test_clear(input logic [31:0] w);
      int t;
      int err;
      bit ok;
      log_clear();
      send(w);
      t = cyc - 1;
      wait_idle(2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL clr_idle: got busy want idle"); end
      total++; if (wr_cyc.size() != 768) begin bad++; $display("FAIL clr_count: got %0d want 768", wr_cyc.size()); end
      err = 0;
      foreach (wr_cyc[i]) begin
         if (wr_cyc[i] != t + 3 + i || wr_addr[i] != 10'(i) || wr_data[i] != 8'hFF) err++;
      end
      total++; if (err != 0) begin bad++; $display("FAIL clr_seq: got %0d bad pixels want 0", err); end
      total++; if (wr_cyc.size() > 0 && wr_cyc[wr_cyc.size()-1] != t + 770)
         begin bad++; $display("FAIL clr_last: got T+%0d want T+770", wr_cyc[wr_cyc.size()-1] - t); end
   endtask

   task automatic test_range();
      log_clear();
      send(pt(5'd3, 5'd30, 8'h0F));
      step();
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rng_pt_level: got %0d want 0", fifo_level); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rng_pt_busy: got %0d want 0", busy); end
      send(rect(5'd10, 5'd0, 5'd4, 5'd5, 8'hAA));
      step();
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rng_rect_busy: got %0d want 0", busy); end
      send(rect(5'd0, 5'd25, 5'd31, 5'd31, 8'h55));
      step();
      step();
      step();
      total++; if (wr_cyc.size() != 0) begin bad++; $display("FAIL rng_nowrite: got %0d writes want 0", wr_cyc.size()); end
      send(pt(5'd31, 5'd23, 8'h3C));
      step();
      total++; if (fb_we !== 1'b1 || fb_addr !== 10'd767 || fb_wdata !== 8'h3C)
         begin bad++; $display("FAIL rng_corner_pt: got we=%0d a=%0d d=%0h want we=1 a=767 d=3c", fb_we, fb_addr, fb_wdata); end
      send(rect(5'd31, 5'd23, 5'd31, 5'd31, 8'h11));
      step();
      step();
      step();
      total++; if (wr_cyc.size() != 2 || wr_addr[1] != 10'd767 || wr_data[1] != 8'h11)
         begin bad++; $display("FAIL rng_corner_rect: got n=%0d want n=2 a=767 d=11", wr_cyc.size()); end
   endtask

   task automatic test_skip();
      int t;
      log_clear();
      send(32'h91943C00);
      t = cyc - 1;
      send(32'hA1943C00);
      send(32'h91943C00);
      send(32'hA1943C00);
      send(PT35);
      repeat (6) step();
      total++; if (wr_cyc.size() != 1) begin bad++; $display("FAIL skip_count: got %0d want 1", wr_cyc.size()); end
      total++; if (wr_cyc.size() > 0 && (wr_cyc[0] != t + 6 || wr_addr[0] != 10'd163))
         begin bad++; $display("FAIL skip_point: got T+%0d a=%0d want T+6 a=163", wr_cyc[0] - t, wr_addr[0]); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL skip_busy: got %0d want 0", busy); end
   endtask

   task automatic test_overflow();
      int t;
      int err;
      bit ok;
      log_clear();
      send(CLEAR);
      t = cyc - 1;
      for (int i = 0; i < 17; i++) begin
         cmd     = pt(5'(i), 5'd1, 8'(i + 1));
         cmd_vld = 1'b1;
         step();
         if (i == 15) begin
            total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_full: got %0d want 16", fifo_level); end
            total++; if (cmd_ovf !== 1'b0)     begin bad++; $display("FAIL ovf_early: got %0d want 0", cmd_ovf); end
         end
      end
      cmd_vld = 1'b0;
      total++; if (cmd_ovf !== 1'b1)     begin bad++; $display("FAIL ovf_flag: got %0d want 1", cmd_ovf); end
      total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
      wait_idle(2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL ovf_idle: got busy want idle"); end
      total++; if (wr_cyc.size() != 784) begin bad++; $display("FAIL ovf_count: got %0d want 784", wr_cyc.size()); end
      err = 0;
      if (wr_cyc.size() == 784) begin
         for (int i = 0; i < 16; i++) begin
            if (wr_cyc[768+i] != t + 771 + i || wr_addr[768+i] != 10'(32 + i) || wr_data[768+i] != 8'(i + 1)) err++;
         end
      end else begin
         err = 16;
      end
      total++; if (err != 0) begin bad++; $display("FAIL ovf_points: got %0d bad points want 0", err); end
      total++; if (cmd_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0d want 1", cmd_ovf); end
   endtask

   task automatic test_reset_mid_fill();
      int t;
      log_clear();
      send(CLEAR);
      t = cyc - 1;
      send(pt(5'd1, 5'd1, 8'h01));
      send(pt(5'd2, 5'd2, 8'h02));
      while (cyc < t + 100) step();
      total++; if (fifo_level !== 5'd2 || fb_we !== 1'b1)
         begin bad++; $display("FAIL rmf_pre: got lvl=%0d we=%0d want lvl=2 we=1", fifo_level, fb_we); end
      #2 rst = 1'b1;
      #1;
      total++; if (fb_we !== 1'b0)      begin bad++; $display("FAIL rmf_we: got %0d want 0", fb_we); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rmf_level: got %0d want 0", fifo_level); end
      total++; if (cmd_ovf !== 1'b0)    begin bad++; $display("FAIL rmf_ovf: got %0d want 0", cmd_ovf); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rmf_busy: got %0d want 0", busy); end
      log_clear();
      #4 rst = 1'b0;
      repeat (50) step();
      total++; if (wr_cyc.size() != 0) begin bad++; $display("FAIL rmf_quiet: got %0d writes want 0", wr_cyc.size()); end
      send(PT35);
      repeat (3) step();
      total++; if (wr_cyc.size() != 1 || wr_addr[0] != 10'd163)
         begin bad++; $display("FAIL rmf_resume: got n=%0d want n=1 a=163", wr_cyc.size()); end
   endtask

   initial begin
      test_reset();
      test_point();
      test_clear(CLEAR);
      test_clear(CLEAR_Y31);
      test_range();
      test_skip();
      test_overflow();
      test_reset_mid_fill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/draw_cmd_exec.md
# draw_cmd_exec

Consumer end of the 32-bit draw-command stream emitted by the game core (`cmd`/`cmd_vld`). Buffers commands in a small FIFO, decodes the logic-grid opcodes (single point, rectangle fill), and turns them into one-pixel-per-cycle writes to the logic-grid frame buffer that the VGA scan-out reads. Pixel-layer opcodes (line, character) are owned by a separate renderer; this block consumes and discards them.

## Interface
- H_LOGIC_WIDTH, 5, logic x coordinate width
- V_LOGIC_WIDTH, 5, logic y coordinate width
- H_LOGIC_MAX, 5'd31, last valid logic column
- V_LOGIC_MAX, 5'd23, last valid logic row
- COLOR_ID_WIDTH, 8, color index width
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- cmd  in  32  draw command word
- cmd_vld  in  1  `cmd` valid this cycle; no ready, the producer never stalls
- fb_we  out  1  frame-buffer write strobe
- fb_addr  out  V_LOGIC_WIDTH+H_LOGIC_WIDTH  `{y, x}`, i.e. y*32+x at defaults
- fb_wdata  out  COLOR_ID_WIDTH  color index
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE
- fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..16
- cmd_ovf  out  1  sticky flag; set when a command is dropped because the FIFO is full

## Operation
- Opcode is `cmd[31:28]`.
- **Op 0, point:** x=[27:23], y=[22:18], color=[17:10]. Bits [9:0] are ignored.
  - If x>H_LOGIC_MAX or y>V_LOGIC_MAX: word consumed, no write.
- **Op 1, rectangle fill:** x0=[27:23], y0=[22:18], x1=[17:13], y1=[12:8], color=[7:0].
  - x1 is clipped to H_LOGIC_MAX; y1 is clipped to V_LOGIC_MAX.
  - If x0>x1 or y0>y1 after clipping: no writes.
  - Otherwise writes are issued row-major: for y0..y1, inner loop x0..x1.
- **Ops 2–15:** word consumed, no write, one cycle per word. This covers reserved ops and the two-word ops 9/A; each word is dropped independently.
- **FIFO:** show-ahead.
  - Push when `cmd_vld` is high and fifo_level<16.
  - If `cmd_vld` is high and fifo_level==16: the word is lost and cmd_ovf is set, even if a pop occurs in the same cycle.
  - Pointers wrap modulo 16. Simultaneous push and pop leave the level unchanged.
- **FSM states:** IDLE and FILL.
  - IDLE with FIFO non-empty: pop the head word.
    - Point: register the write directly; stay IDLE.
    - Valid fill: load cx=x0, cy=y0 and the clipped bounds; go to FILL.
    - Any other case: stay IDLE.
  - FILL, each cycle: register the write of (cx,cy).
    - If cx==x1: set cx=x0 and increment cy; otherwise increment cx.
    - After the write of (x1,y1): go to IDLE. Nothing is popped while in FILL.
- **Reset values:** fb_we=0, fb_addr=0, fb_wdata=0, busy=0, fifo_level=0, cmd_ovf=0, state IDLE.
  - Reset mid-fill aborts the fill and empties the FIFO.
  - cmd_ovf clears only on reset.

## Timing
- Cycle T: `cmd_vld` sampled. The word is in the FIFO at T+1.
- Point: popped at T+1; fb_we high in cycle T+2 with addr/data valid. Sustained throughput is one point per cycle.
- Fill of N pixels: popped at T+1; writes occur in cycles T+3 .. T+2+N, one per cycle, with no gaps. The next word is popped at T+2+N.
- fb_we is a single-cycle strobe per pixel. fb_addr/fb_wdata hold their last value when fb_we=0.
- busy is combinational from state and level. It drops in the cycle after the last write's pop/FILL exit, once the FIFO is empty.

## Test plan
1. Point: cmd=0x01943C00 (x=3, y=5, color 0x0F) at T -> fb_we only at T+2, fb_addr=163, fb_wdata=0x0F; fifo_level returns to 0 at T+2.
2. Clear screen: cmd=0x1003F7FF -> exactly 768 writes at T+3..T+770, addr 0..767 ascending, data 0xFF.
   - Repeat with y1=31: still 768 writes (clipped).
3. Overflow: issue clear screen, then 17 back-to-back points during the fill -> 16 accepted, 17th dropped, cmd_ovf=1.
   - After the fill, the 16 points are written on consecutive cycles in order.
4. Range: point at y=30 -> no write. Rect with x0=10, x1=4 -> no write. In both cases the word is consumed and busy drops.
5. Skip: 0x9/0xA word pairs followed by point 0x01943C00 -> no writes for the 0x9/0xA words; the point is written 4 cycles after its predecessors drain (one cycle per skipped word).
6. Reset mid-fill (pulse rst asynchronously at cycle T+100 of a clear) -> fb_we=0, fifo_level=0, cmd_ovf=0 immediately; no writes after release until a new cmd arrives.
